// File: rtl/ci_pkg.sv
// Shared types, block-size constants and modular helpers for the QPP interleaver core.
package ci_pkg;

    localparam int unsigned IDX_W  = 14;
    localparam int unsigned BYTE_W = 10;

    localparam int unsigned K_S  = 1056;
    localparam int unsigned F1_S = 17;
    localparam int unsigned F2_S = 66;
    localparam int unsigned K_L  = 6144;
    localparam int unsigned F1_L = 263;
    localparam int unsigned F2_L = 480;

    // Recursion seeds: g(0) = (f1+f2) mod K, step = 2*f2 mod K
    localparam int unsigned G0_S   = (F1_S + F2_S) % K_S;
    localparam int unsigned STEP_S = (2 * F2_S) % K_S;
    localparam int unsigned G0_L   = (F1_L + F2_L) % K_L;
    localparam int unsigned STEP_L = (2 * F2_L) % K_L;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [IDX_W-1:0] blk_k(input logic big);
        return big ? IDX_W'(K_L) : IDX_W'(K_S);
    endfunction

    function automatic logic [IDX_W-1:0] blk_g0(input logic big);
        return big ? IDX_W'(G0_L) : IDX_W'(G0_S);
    endfunction

    function automatic logic [IDX_W-1:0] blk_step(input logic big);
        return big ? IDX_W'(STEP_L) : IDX_W'(STEP_S);
    endfunction

    function automatic logic [BYTE_W-1:0] blk_last_byte(input logic big);
        return big ? BYTE_W'(K_L / 8 - 1) : BYTE_W'(K_S / 8 - 1);
    endfunction

    // (a + b) mod k for a, b < k: one conditional subtract
    function automatic logic [IDX_W-1:0] mod_add(input logic [IDX_W-1:0] a,
                                                 input logic [IDX_W-1:0] b,
                                                 input logic [IDX_W-1:0] k);
        logic [IDX_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= {1'b0, k}) begin
            sum = sum - {1'b0, k};
        end
        return sum[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/hex_digit_decoder.sv
// Hex nibble to 7-segment pattern, bit order {g,f,e,d,c,b,a}; polarity set by SEG_ACTIVE_LOW.
module hex_digit_decoder #(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    logic [6:0] lit_c;

    always_comb begin
        lit_c = 7'h00;
        case (nibble)
            4'h0: lit_c = 7'h3F;
            4'h1: lit_c = 7'h06;
            4'h2: lit_c = 7'h5B;
            4'h3: lit_c = 7'h4F;
            4'h4: lit_c = 7'h66;
            4'h5: lit_c = 7'h6D;
            4'h6: lit_c = 7'h7D;
            4'h7: lit_c = 7'h07;
            4'h8: lit_c = 7'h7F;
            4'h9: lit_c = 7'h6F;
            4'hA: lit_c = 7'h77;
            4'hB: lit_c = 7'h7C;
            4'hC: lit_c = 7'h39;
            4'hD: lit_c = 7'h5E;
            4'hE: lit_c = 7'h79;
            default: lit_c = 7'h71;
        endcase
    end

    assign seg = SEG_ACTIVE_LOW ? ~lit_c : lit_c;

endmodule

// File: rtl/coder_interleaver_core.sv
// LTE turbo-coder QPP interleaver: byte-serial block load, then bit-serial c[i] / c[pi(i)] stream.
// Optional hex debug display enabled by defining CI_HEX_DISPLAY_EN.
module coder_interleaver_core
    import ci_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic             CLOCK_50,
    input  logic             KEY_0,
    input  logic             k_size_6144,
    input  logic             ready_in,
    input  logic [7:0]       databit_in1,
    input  logic             data_valid,
    input  logic             switch,
    output logic             outi,
    output logic             outpii,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_index,
    output logic [IDX_W-1:0] out_pi_index,
    output logic             busy,
    output logic             done,
    output logic [7:0]       LEDR,
    output logic [6:0]       seg0,
    output logic [6:0]       seg1,
    output logic [6:0]       seg2,
    output logic [6:0]       seg3,
    output logic [6:0]       seg4,
    output logic [6:0]       seg5
);

    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    state_t              state_q, state_d;
    logic                big_q;
    logic [BYTE_W-1:0]   byte_cnt_q;
    logic [IDX_W-1:0]    i_q, pi_q, g_q;
    logic                start_c, wr_en_c;
    logic [7:0]          mem [768];

    // Next-state and load/start strobes
    always_comb begin
        state_d = state_q;
        start_c = 1'b0;
        wr_en_c = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (ready_in) begin
                    state_d = ST_LOAD;
                    start_c = 1'b1;
                end
            end
            ST_LOAD: begin
                if (data_valid) begin
                    wr_en_c = 1'b1;
                    if (byte_cnt_q == blk_last_byte(big_q)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (i_q == blk_k(big_q) - IDX_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Block buffer contents survive reset
    always_ff @(posedge CLOCK_50) begin
        if (wr_en_c) begin
            mem[byte_cnt_q] <= databit_in1;
        end
    end

    // State, counters, QPP recursion and registered read ports
    always_ff @(posedge CLOCK_50 or negedge KEY_0) begin
        if (!KEY_0) begin
            state_q      <= ST_IDLE;
            big_q        <= 1'b0;
            byte_cnt_q   <= '0;
            i_q          <= '0;
            pi_q         <= '0;
            g_q          <= '0;
            outi         <= 1'b0;
            outpii       <= 1'b0;
            out_valid    <= 1'b0;
            out_index    <= '0;
            out_pi_index <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            LEDR         <= '0;
        end else begin
            state_q   <= state_d;
            busy      <= (state_d == ST_LOAD) || (state_d == ST_RUN);
            done      <= (state_d == ST_DONE);
            out_valid <= (state_q == ST_RUN);
            if (start_c) begin
                big_q      <= k_size_6144;
                byte_cnt_q <= '0;
            end
            if (wr_en_c) begin
                byte_cnt_q <= byte_cnt_q + BYTE_W'(1);
                LEDR       <= databit_in1;
            end
            if (state_q == ST_LOAD) begin
                i_q  <= '0;
                pi_q <= '0;
                g_q  <= blk_g0(big_q);
            end else if (state_q == ST_RUN) begin
                i_q          <= i_q + IDX_W'(1);
                pi_q         <= mod_add(pi_q, g_q, blk_k(big_q));
                g_q          <= mod_add(g_q, blk_step(big_q), blk_k(big_q));
                outi         <= mem[i_q[12:3]][~i_q[2:0]];
                outpii       <= mem[pi_q[12:3]][~pi_q[2:0]];
                out_index    <= i_q;
                out_pi_index <= pi_q;
            end
        end
    end

`ifdef CI_HEX_DISPLAY_EN
    logic [3:0] nib_c [6];
    logic [6:0] seg_c [6];

    // Digit sources: switch=1 shows stream state, switch=0 shows load progress
    always_comb begin
        for (int d = 0; d < 6; d++) begin
            nib_c[d] = 4'h0;
        end
        if (switch) begin
            nib_c[0] = out_pi_index[3:0];
            nib_c[1] = out_pi_index[7:4];
            nib_c[2] = out_pi_index[11:8];
            nib_c[3] = {2'b00, out_pi_index[13:12]};
            nib_c[4] = {2'b00, outi, outpii};
            nib_c[5] = {2'b00, 2'(state_q)};
        end else begin
            nib_c[0] = LEDR[3:0];
            nib_c[1] = LEDR[7:4];
            nib_c[2] = byte_cnt_q[3:0];
            nib_c[3] = byte_cnt_q[7:4];
            nib_c[4] = {2'b00, byte_cnt_q[9:8]};
        end
    end

    for (genvar d = 0; d < 6; d++) begin : g_hex
        hex_digit_decoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec (
            .nibble (nib_c[d]),
            .seg    (seg_c[d])
        );
    end

    always_ff @(posedge CLOCK_50 or negedge KEY_0) begin
        if (!KEY_0) begin
            seg0 <= SEG_OFF;
            seg1 <= SEG_OFF;
            seg2 <= SEG_OFF;
            seg3 <= SEG_OFF;
            seg4 <= SEG_OFF;
            seg5 <= SEG_OFF;
        end else begin
            seg0 <= seg_c[0];
            seg1 <= seg_c[1];
            seg2 <= seg_c[2];
            seg3 <= seg_c[3];
            seg4 <= seg_c[4];
            seg5 <= seg_c[5];
        end
    end
`else
    logic unused_display;
    assign unused_display = switch;
    assign seg0 = SEG_OFF;
    assign seg1 = SEG_OFF;
    assign seg2 = SEG_OFF;
    assign seg3 = SEG_OFF;
    assign seg4 = SEG_OFF;
    assign seg5 = SEG_OFF;
`endif

endmodule

// File: tb/tb_coder_interleaver_core.sv
// Scoreboard bench for coder_interleaver_core: expected (i, pi(i), c[i], c[pi(i)]) from a closed-form QPP model.
module tb_coder_interleaver_core;
    import ci_pkg::*;

    logic             clk = 1'b0;
    logic             KEY_0;
    logic             k_size_6144;
    logic             ready_in;
    logic [7:0]       databit_in1;
    logic             data_valid;
    logic             switch;
    logic             outi, outpii, out_valid, busy, done;
    logic [IDX_W-1:0] out_index, out_pi_index;
    logic [7:0]       LEDR;
    logic [6:0]       seg0, seg1, seg2, seg3, seg4, seg5;

    always #5 clk = ~clk;

    coder_interleaver_core dut (
        .CLOCK_50     (clk),
        .KEY_0        (KEY_0),
        .k_size_6144  (k_size_6144),
        .ready_in     (ready_in),
        .databit_in1  (databit_in1),
        .data_valid   (data_valid),
        .switch       (switch),
        .outi         (outi),
        .outpii       (outpii),
        .out_valid    (out_valid),
        .out_index    (out_index),
        .out_pi_index (out_pi_index),
        .busy         (busy),
        .done         (done),
        .LEDR         (LEDR),
        .seg0         (seg0),
        .seg1         (seg1),
        .seg2         (seg2),
        .seg3         (seg3),
        .seg4         (seg4),
        .seg5         (seg5)
    );

    typedef struct { int idx; int pi; bit ci; bit cpi; } exp_t;
    typedef struct { int i; int pi; } spot_t;

    exp_t       exp_q[$];
    spot_t      spot_q[$];
    logic [7:0] blk [768];
    int         n_pass = 0;
    int         n_total = 0;

    function automatic int tb_k(input bit big);
        return big ? 6144 : 1056;
    endfunction

    // Closed form pi(i) = (f1*i + f2*i^2) mod K
    function automatic int pi_model(input int i, input bit big);
        longint f1, f2, k, li;
        f1 = big ? 263 : 17;
        f2 = big ? 480 : 66;
        k  = longint'(tb_k(big));
        li = longint'(i);
        return int'((f1 * li + f2 * li * li) % k);
    endfunction

    function automatic bit cbit(input int n);
        logic [7:0] b;
        b = blk[n / 8];
        return b[7 - (n % 8)];
    endfunction

    task automatic clear_blk();
        foreach (blk[b]) blk[b] = 8'h00;
    endtask

    task automatic random_blk();
        foreach (blk[b]) blk[b] = 8'($urandom_range(0, 255));
    endtask

    task automatic push_expected(input bit big);
        exp_t e;
        for (int i = 0; i < tb_k(big); i++) begin
            e.idx = i;
            e.pi  = pi_model(i, big);
            e.ci  = cbit(i);
            e.cpi = cbit(e.pi);
            exp_q.push_back(e);
        end
    endtask

    // Start pulse plus byte stream; optional gaps carry ignored ready_in pulses
    task automatic load_block(input bit big, input bit gaps);
        push_expected(big);
        @(posedge clk); #1;
        k_size_6144 = big;
        ready_in    = 1'b1;
        @(posedge clk); #1;
        ready_in    = 1'b0;
        k_size_6144 = ~big;
        for (int b = 0; b < tb_k(big) / 8; b++) begin
            if (gaps && (b % 7 == 3)) begin
                data_valid  = 1'b0;
                databit_in1 = 8'hA5;
                ready_in    = 1'b1;
                @(posedge clk); #1;
                ready_in    = 1'b0;
                @(posedge clk); #1;
            end
            databit_in1 = blk[b];
            data_valid  = 1'b1;
            @(posedge clk); #1;
        end
        data_valid  = 1'b0;
        databit_in1 = 8'h00;
    endtask

    task automatic collect(input string name, input bit big, input bit noise, input int abort_at);
        int   k;
        int   seen;
        int   cyc;
        int   first;
        int   last;
        bit   aborted;
        exp_t e;
        k = tb_k(big); seen = 0; cyc = 0; first = -1; last = -1; aborted = 1'b0;
        while (seen < k && cyc < k + 50 && !aborted) begin
            @(negedge clk);
            cyc++;
            ready_in = noise && (cyc % 97 == 5) && (seen < k - 10);
            if (out_valid === 1'b1) begin
                if (first < 0) first = cyc;
                last = cyc;
                seen++;
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL %s extra_output: got idx=%0d, want no output", name, out_index);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_index, out_pi_index, outi, outpii} !==
                        {IDX_W'(e.idx), IDX_W'(e.pi), e.ci, e.cpi}) begin
                        $display("FAIL %s stream: got i=%0d pi=%0d ci=%0b cpi=%0b, want i=%0d pi=%0d ci=%0b cpi=%0b",
                                 name, out_index, out_pi_index, outi, outpii, e.idx, e.pi, e.ci, e.cpi);
                    end else begin
                        n_pass++;
                    end
                end
                foreach (spot_q[s]) begin
                    if (spot_q[s].i == seen - 1) begin
                        n_total++;
                        if (out_pi_index !== IDX_W'(spot_q[s].pi)) begin
                            $display("FAIL %s spot_pi(%0d): got %0d, want %0d",
                                     name, spot_q[s].i, out_pi_index, spot_q[s].pi);
                        end else begin
                            n_pass++;
                        end
                    end
                end
                if (seen - 1 == abort_at) begin
                    KEY_0 = 1'b0;
                    @(negedge clk);
                    n_total++;
                    if ({out_valid, busy, done} !== 3'b000) begin
                        $display("FAIL %s abort_idle: got valid/busy/done=%b, want 000", name,
                                 {out_valid, busy, done});
                    end else begin
                        n_pass++;
                    end
                    KEY_0 = 1'b1;
                    exp_q.delete();
                    aborted = 1'b1;
                end
            end
        end
        ready_in = 1'b0;
        spot_q.delete();
        if (!aborted) begin
            n_total++;
            if (seen != k || last - first != k - 1 || exp_q.size() != 0) begin
                $display("FAIL %s stream_len: got %0d valid over %0d cycles, want %0d contiguous",
                         name, seen, last - first + 1, k);
            end else begin
                n_pass++;
            end
            @(negedge clk);
            n_total++;
            if ({done, busy, out_valid} !== 3'b100 || out_index !== IDX_W'(k - 1) ||
                out_pi_index !== IDX_W'(pi_model(k - 1, big))) begin
                $display("FAIL %s done_hold: got done/busy/valid=%b i=%0d pi=%0d, want 100 i=%0d pi=%0d",
                         name, {done, busy, out_valid}, out_index, out_pi_index, k - 1,
                         pi_model(k - 1, big));
            end else begin
                n_pass++;
            end
        end
    endtask

    task automatic test_reset();
        KEY_0 = 1'b0; k_size_6144 = 1'b0; ready_in = 1'b0; databit_in1 = 8'h00;
        data_valid = 1'b0; switch = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({out_valid, busy, done} !== 3'b000 || LEDR !== 8'h00 || out_index !== '0) begin
            $display("FAIL reset_state: got valid/busy/done=%b LEDR=%h i=%0d, want 000 00 0",
                     {out_valid, busy, done}, LEDR, out_index);
        end else begin
            n_pass++;
        end
        KEY_0 = 1'b1;
        repeat (6) @(negedge clk);
        n_total++;
        if ({out_valid, busy, done} !== 3'b000) begin
            $display("FAIL reset_stay_idle: got valid/busy/done=%b, want 000", {out_valid, busy, done});
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_single_bit();
        clear_blk();
        blk[0] = 8'h80;
        load_block(1'b0, 1'b0);
        n_total++;
        if (LEDR !== 8'h00 || busy !== 1'b1) begin
            $display("FAIL single_ledr_busy: got LEDR=%h busy=%b, want 00 1", LEDR, busy);
        end else begin
            n_pass++;
        end
        spot_q.push_back('{0, 0});
        collect("single_bit", 1'b0, 1'b0, -1);
    endtask

    task automatic test_c83();
        clear_blk();
        blk[10] = 8'h10;
        load_block(1'b0, 1'b0);
        spot_q.push_back('{1, 83});
        spot_q.push_back('{2, 298});
        spot_q.push_back('{1055, 49});
        collect("c83", 1'b0, 1'b0, -1);
    endtask

    task automatic test_k6144();
        random_blk();
        load_block(1'b1, 1'b0);
        spot_q.push_back('{0, 0});
        spot_q.push_back('{1, 743});
        spot_q.push_back('{2, 2446});
        spot_q.push_back('{6143, 217});
        collect("k6144", 1'b1, 1'b0, -1);
    endtask

    task automatic test_gaps_and_ignored_ready();
        random_blk();
        load_block(1'b0, 1'b1);
        n_total++;
        if (LEDR !== blk[131]) begin
            $display("FAIL gaps_ledr: got %h, want %h", LEDR, blk[131]);
        end else begin
            n_pass++;
        end
        collect("gaps", 1'b0, 1'b1, -1);
    endtask

    task automatic test_reset_mid_run();
        random_blk();
        load_block(1'b0, 1'b0);
        collect("abort", 1'b0, 1'b0, 500);
        load_block(1'b0, 1'b0);
        collect("reload", 1'b0, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_single_bit();
        test_c83();
        test_k6144();
        test_gaps_and_ignored_ready();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
